// File: rtl/serial_rx_lanes.sv
// Multi-lane serial word receiver with comma-based word alignment.
// Each lane hunts for COMMA, confirms alignment, then strobes out data words.
module serial_rx_lanes #(
    parameter int                LANES       = 2,
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  COMMA       = WIDTH'('hBC),
    parameter int                LOCK_COMMAS = 4
) (
    input  logic                   clk_8f,
    input  logic                   reset,
    input  logic [LANES-1:0]       data_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES-1:0]       locked,
    output logic                   all_locked,
    output logic [LANES-1:0]       realign
);

    localparam int              CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
    localparam logic [3:0]      NLOCK = 4'(LOCK_COMMAS);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } state_t;

    logic [LANES-1:0] lane_locked;

    assign locked = lane_locked;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t           state_q, state_d;
        logic [WIDTH-1:0] sr_q;
        logic [WIDTH-1:0] nxt;
        logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
        logic [3:0]       ccnt_q, ccnt_d, ccnt_inc;
        logic [WIDTH-1:0] word_q, word_d;
        logic             valid_q, valid_d;
        logic             realign_q, realign_d;
        logic             is_comma;
        logic             at_last;

        assign nxt      = {sr_q[WIDTH-2:0], data_in[i]};
        assign is_comma = (nxt == COMMA);
        assign at_last  = (cnt_q == LAST);
        assign cnt_inc  = at_last ? '0 : cnt_q + 1'b1;
        assign ccnt_inc = ccnt_q + 4'd1;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            ccnt_d    = ccnt_q;
            word_d    = word_q;
            valid_d   = 1'b0;
            realign_d = 1'b0;
            unique case (state_q)
                SEARCH: begin
                    cnt_d = '0;
                    if (is_comma) begin
                        ccnt_d  = 4'd1;
                        state_d = (NLOCK == 4'd1) ? LOCKED : ALIGN;
                    end
                end
                ALIGN: begin
                    cnt_d = cnt_inc;
                    if (at_last) begin
                        if (is_comma) begin
                            ccnt_d = ccnt_inc;
                            if (ccnt_inc >= NLOCK) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            state_d = SEARCH;
                            ccnt_d  = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    cnt_d = cnt_inc;
                    // a comma off the word grid wins over boundary handling
                    if (is_comma && !at_last) begin
                        state_d   = ALIGN;
                        ccnt_d    = 4'd1;
                        cnt_d     = '0;
                        realign_d = 1'b1;
                    end else if (at_last && !is_comma) begin
                        word_d  = nxt;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                    ccnt_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk_8f or negedge reset) begin
            if (!reset) begin
                state_q   <= SEARCH;
                sr_q      <= '0;
                cnt_q     <= '0;
                ccnt_q    <= '0;
                word_q    <= '0;
                valid_q   <= 1'b0;
                realign_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                sr_q      <= nxt;
                cnt_q     <= cnt_d;
                ccnt_q    <= ccnt_d;
                word_q    <= word_d;
                valid_q   <= valid_d;
                realign_q <= realign_d;
            end
        end

        assign data_out[i*WIDTH +: WIDTH] = word_q;
        assign valid_out[i]               = valid_q;
        assign realign[i]                 = realign_q;
        assign lane_locked[i]             = (state_q == LOCKED);
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= &lane_locked;
        end
    end

endmodule

// File: tb/tb_serial_rx_lanes.sv
// Bench for serial_rx_lanes: default config plus a 4-lane 10-bit config.
// Reference model tracks word phase by bit index arithmetic per lane.
module tb_serial_rx_lanes;

    logic        clk;
    logic        reset;
    logic [1:0]  din0;
    logic [15:0] dout0;
    logic [1:0]  v0, lk0, ra0;
    logic        al0;
    logic [3:0]  din1;
    logic [39:0] dout1;
    logic [3:0]  v1, lk1, ra1;
    logic        al1;

    serial_rx_lanes dut0 (
        .clk_8f    (clk),
        .reset     (reset),
        .data_in   (din0),
        .data_out  (dout0),
        .valid_out (v0),
        .locked    (lk0),
        .all_locked(al0),
        .realign   (ra0)
    );

    serial_rx_lanes #(
        .LANES      (4),
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COMMAS(4)
    ) dut1 (
        .clk_8f    (clk),
        .reset     (reset),
        .data_in   (din1),
        .data_out  (dout1),
        .valid_out (v1),
        .locked    (lk1),
        .all_locked(al1),
        .realign   (ra1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int nv0    = 0;

    localparam int LOCK = 4;

    int m_n   [2][4];
    int m_anc [2][4];
    int m_mode[2][4];
    int m_cnt [2][4];
    int m_w   [2][4];
    int m_dat [2][4];
    bit m_v   [2][4];
    bit m_ra  [2][4];
    bit m_all [2];

    int g_word[2][4];
    int g_len [2][4];
    int g_pos [2][4];

    typedef struct {
        string      name;
        int         npre;
        logic [7:0] a0, b0, a1, b1;
        logic [1:0] exp_lk;
        int         exp_nv0;
        logic [7:0] exp_d0;
    } vec_t;

    vec_t tbl[6];

    function automatic int wd(input int c);
        return (c == 0) ? 8 : 10;
    endfunction

    function automatic int cm(input int c);
        return (c == 0) ? 'hBC : 'h17C;
    endfunction

    function automatic int nl(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_all[c] = 1'b0;
            for (int l = 0; l < 4; l++) begin
                m_n[c][l]    = 0;
                m_anc[c][l]  = 0;
                m_mode[c][l] = 0;
                m_cnt[c][l]  = 0;
                m_w[c][l]    = 0;
                m_dat[c][l]  = 0;
                m_v[c][l]    = 1'b0;
                m_ra[c][l]   = 1'b0;
            end
        end
    endfunction

    // mode 0 = hunting, 1 = confirming, 2 = locked
    function automatic void model_lane(input int c, input int l, input bit b);
        int w;
        bit hit, on;
        w = wd(c);
        m_v[c][l]  = 1'b0;
        m_ra[c][l] = 1'b0;
        m_n[c][l]++;
        m_w[c][l] = ((m_w[c][l] << 1) | int'(b)) & ((1 << w) - 1);
        hit = (m_w[c][l] == cm(c));
        on  = ((m_n[c][l] - m_anc[c][l]) % w) == 0;
        if (m_mode[c][l] == 0) begin
            if (hit) begin
                m_anc[c][l]  = m_n[c][l];
                m_cnt[c][l]  = 1;
                m_mode[c][l] = (m_cnt[c][l] >= LOCK) ? 2 : 1;
            end
        end else if (m_mode[c][l] == 1) begin
            if (on) begin
                if (hit) begin
                    m_cnt[c][l]++;
                    if (m_cnt[c][l] >= LOCK) m_mode[c][l] = 2;
                end else begin
                    m_mode[c][l] = 0;
                    m_cnt[c][l]  = 0;
                end
            end
        end else begin
            if (hit && !on) begin
                m_mode[c][l] = 1;
                m_cnt[c][l]  = 1;
                m_anc[c][l]  = m_n[c][l];
                m_ra[c][l]   = 1'b1;
            end else if (on && !hit) begin
                m_dat[c][l] = m_w[c][l];
                m_v[c][l]   = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        logic [15:0] ed0;
        logic [1:0]  ev0, el0, er0;
        logic [39:0] ed1;
        logic [3:0]  ev1, el1, er1;
        for (int l = 0; l < 2; l++) begin
            ed0[l*8 +: 8] = 8'(m_dat[0][l]);
            ev0[l] = m_v[0][l];
            el0[l] = (m_mode[0][l] == 2);
            er0[l] = m_ra[0][l];
        end
        for (int l = 0; l < 4; l++) begin
            ed1[l*10 +: 10] = 10'(m_dat[1][l]);
            ev1[l] = m_v[1][l];
            el1[l] = (m_mode[1][l] == 2);
            er1[l] = m_ra[1][l];
        end
        chk("c0_data", 64'(dout0), 64'(ed0));
        chk("c0_valid", 64'(v0), 64'(ev0));
        chk("c0_locked", 64'(lk0), 64'(el0));
        chk("c0_realign", 64'(ra0), 64'(er0));
        chk("c0_all_locked", 64'(al0), 64'(m_all[0]));
        chk("c1_data", 64'(dout1), 64'(ed1));
        chk("c1_valid", 64'(v1), 64'(ev1));
        chk("c1_locked", 64'(lk1), 64'(el1));
        chk("c1_realign", 64'(ra1), 64'(er1));
        chk("c1_all_locked", 64'(al1), 64'(m_all[1]));
    endtask

    task automatic step_cycle(input logic r, input logic [1:0] b0,
                              input logic [3:0] b1);
        bit all;
        reset = r;
        din0  = b0;
        din1  = b1;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                all = 1'b1;
                for (int l = 0; l < nl(c); l++)
                    if (m_mode[c][l] != 2) all = 1'b0;
                m_all[c] = all;
            end
            for (int l = 0; l < 2; l++) model_lane(0, l, b0[l]);
            for (int l = 0; l < 4; l++) model_lane(1, l, b1[l]);
        end
        #1;
        check_all();
        if (v0[0]) nv0++;
    endtask

    task automatic send_words(input logic [7:0] w0, input logic [7:0] w1);
        for (int k = 7; k >= 0; k--)
            step_cycle(1'b1, {w1[k], w0[k]}, 4'($urandom));
    endtask

    task automatic do_reset(input int n);
        repeat (n) step_cycle(1'b0, 2'($urandom), 4'($urandom));
        nv0 = 0;
    endtask

    function automatic bit gen_bit(input int c, input int l);
        int r, w;
        w = wd(c);
        if (g_pos[c][l] >= g_len[c][l]) begin
            r = int'($urandom_range(0, 9));
            g_pos[c][l] = 0;
            if (r < 4) begin
                g_word[c][l] = cm(c);
                g_len[c][l]  = w;
            end else if (r < 9) begin
                g_word[c][l] = int'($urandom) & ((1 << w) - 1);
                g_len[c][l]  = w;
            end else begin
                g_len[c][l]  = int'($urandom_range(1, w - 1));
                g_word[c][l] = int'($urandom) & ((1 << g_len[c][l]) - 1);
            end
        end
        gen_bit = bit'((g_word[c][l] >> (g_len[c][l] - 1 - g_pos[c][l])) & 1);
        g_pos[c][l]++;
    endfunction

    initial begin
        logic [7:0]  bc;
        logic [9:0]  c10;
        logic [10:0] slip;
        logic [3:0]  b1;
        logic [1:0]  b0;

        bc    = 8'hBC;
        c10   = 10'h17C;
        reset = 1'b0;
        din0  = '0;
        din1  = '0;
        model_reset();
        for (int c = 0; c < 2; c++)
            for (int l = 0; l < 4; l++) begin
                g_len[c][l] = 0;
                g_pos[c][l] = 0;
                g_word[c][l] = 0;
            end

        tbl[0] = '{"data_then_comma", 4, 8'h5A, 8'hBC, 8'hBC, 8'hBC, 2'b11, 1, 8'h5A};
        tbl[1] = '{"two_data",        4, 8'h12, 8'h34, 8'hBC, 8'hBC, 2'b11, 2, 8'h34};
        tbl[2] = '{"lane1_lost",      3, 8'hBC, 8'hBC, 8'h00, 8'hBC, 2'b01, 0, 8'h00};
        tbl[3] = '{"data_both",       4, 8'hA5, 8'hC3, 8'h00, 8'h00, 2'b11, 2, 8'hC3};
        tbl[4] = '{"four_commas",     2, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 2'b11, 0, 8'h00};
        tbl[5] = '{"three_commas",    1, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 2'b00, 0, 8'h00};

        // reset held with random data: outputs stay zero
        do_reset(8);
        chk("rst_dout0", 64'(dout0), 64'd0);
        chk("rst_dout1", 64'(dout1), 64'd0);

        // lock timing on default config
        do_reset(2);
        for (int k = 0; k < 33; k++) begin
            step_cycle(1'b1, {2{bc[7 - (k % 8)]}}, 4'($urandom));
            if (k == 30) chk("lock_k30", 64'(lk0), 64'd0);
            if (k == 31) chk("lock_k31", 64'(lk0), 64'h3);
            if (k == 31) chk("all_k31", 64'(al0), 64'd0);
            if (k == 32) chk("all_k32", 64'(al0), 64'd1);
        end

        for (int i = 0; i < 6; i++) begin
            do_reset(2);
            repeat (tbl[i].npre) send_words(8'hBC, 8'hBC);
            send_words(tbl[i].a0, tbl[i].a1);
            send_words(tbl[i].b0, tbl[i].b1);
            chk({tbl[i].name, "_locked"}, 64'(lk0), 64'(tbl[i].exp_lk));
            chk({tbl[i].name, "_nvalid"}, 64'(nv0), 64'(tbl[i].exp_nv0));
            chk({tbl[i].name, "_data"}, 64'(dout0[7:0]), 64'(tbl[i].exp_d0));
        end

        // misaligned comma on lane0 then relock
        do_reset(2);
        repeat (4) send_words(8'hBC, 8'hBC);
        slip = {3'b000, 8'hBC};
        for (int k = 0; k < 11 + 24; k++) begin
            b0[1] = bc[7 - (k % 8)];
            b0[0] = (k < 11) ? slip[10 - k] : bc[7 - ((k - 11) % 8)];
            step_cycle(1'b1, b0, 4'($urandom));
            if (k == 9)  chk("slip_pre_ra", 64'(ra0), 64'd0);
            if (k == 10) chk("slip_ra", 64'(ra0), 64'h1);
            if (k == 10) chk("slip_unlock", 64'(lk0), 64'h2);
            if (k == 11) chk("slip_ra_end", 64'(ra0), 64'd0);
            if (k == 33) chk("slip_k33", 64'(lk0[0]), 64'd0);
            if (k == 34) chk("slip_relock", 64'(lk0), 64'h3);
        end

        // async reset mid-word while locked
        do_reset(2);
        repeat (4) send_words(8'hBC, 8'hBC);
        for (int k = 7; k > 4; k--)
            step_cycle(1'b1, {bc[k], 1'(8'h5A >> k)}, 4'($urandom));
        #2;
        reset = 1'b0;
        #1;
        chk("async_lk0", 64'(lk0), 64'd0);
        chk("async_lk1", 64'(lk1), 64'd0);
        chk("async_dout0", 64'(dout0), 64'd0);
        step_cycle(1'b0, 2'b00, 4'($urandom));
        nv0 = 0;
        repeat (3) send_words(8'hBC, 8'hBC);
        chk("rst_relock_3", 64'(lk0), 64'd0);
        send_words(8'hBC, 8'hBC);
        chk("rst_relock_4", 64'(lk0), 64'h3);

        // 4-lane 10-bit config with lanes offset 0..3 bits
        do_reset(2);
        for (int k = 0; k < 48; k++) begin
            for (int l = 0; l < 4; l++)
                b1[l] = (k < l) ? 1'b0 : c10[9 - ((k - l) % 10)];
            step_cycle(1'b1, 2'($urandom), b1);
            if (k == 39) chk("wide_k39", 64'(lk1), 64'h1);
            if (k == 42) chk("wide_k42", 64'(lk1), 64'hF);
            if (k == 42) chk("wide_all_k42", 64'(al1), 64'd0);
            if (k == 43) chk("wide_all_k43", 64'(al1), 64'd1);
        end

        // randomized word streams against the model
        do_reset(2);
        for (int k = 0; k < 6000; k++) begin
            for (int l = 0; l < 2; l++) b0[l] = gen_bit(0, l);
            for (int l = 0; l < 4; l++) b1[l] = gen_bit(1, l);
            if (k == 3000)
                step_cycle(1'b0, b0, b1);
            else
                step_cycle(1'b1, b0, b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
